renkon_ctrl_stream: RTL and testbench
=====================================

RENKON_CTRL_STREAM -- requirements
Module: renkon_ctrl_stream

Interface
REQ-001 Parameter LWIDTH, default 16, width of the beat count.
REQ-002 Parameter AWIDTH, default 10, width of the bias memory read address.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 xrst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  start pulse; sampled only in IDLE.
REQ-006 count_in  input  LWIDTH  number of beats to issue; latched with req.
REQ-007 base_addr  input  AWIDTH  first bias address; latched with req.
REQ-008 stall  input  1  downstream hold; present only when RENKON_CTRL_STREAM_STALL_EN is defined.
REQ-009 out_begin  output  1  first-beat marker, coincident with out_valid.
REQ-010 out_valid  output  1  one beat per cycle in which it is high.
REQ-011 out_end  output  1  last-beat marker, coincident with out_valid.
REQ-012 bias_addr  output  AWIDTH  bias read address for the current beat.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 ack  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; all outputs are registered.
REQ-016 IDLE with req=1 and count_in>0 at an edge: latch count_in into remaining, latch base_addr into the address counter, go to RUN.
REQ-017 IDLE with req=1 and count_in=0: go to DONE with no beats.
REQ-018 At each RUN edge with stall=0, the block SHALL register out_valid=1 and bias_addr=current address, then increment the address and decrement remaining.
REQ-019 At each RUN edge with stall=1, the block SHALL register out_valid=0, out_begin=0 and out_end=0; address and remaining are held.
REQ-020 out_begin SHALL be 1 only on the first issued beat of a request.
REQ-021 out_end SHALL be 1 only on the beat issued when remaining=1; that same edge moves the FSM to DONE.
REQ-022 count_in=1: out_begin and out_end are both high on the single beat.
REQ-023 Latency: with no stall, the first beat is visible after the second edge following req; beats are contiguous.
REQ-024 DONE: the next edge registers ack=1, clears out_valid, out_begin and out_end, and returns to IDLE.
REQ-025 req is ignored while busy=1; there is no queuing.
REQ-026 bias_addr SHALL wrap modulo 2^AWIDTH; it holds its last value when out_valid=0.
REQ-027 Total beats per request SHALL equal count_in exactly, regardless of stall pattern.

Reset
REQ-028 xrst=0 SHALL immediately force IDLE and drive out_begin, out_valid, out_end, ack and busy to 0 and bias_addr, remaining and the address counter to 0, including mid-RUN.
REQ-029 After xrst deasserts, no beat SHALL be issued until a new req.

Configuration
REQ-030 Macro RENKON_CTRL_STREAM_STALL_EN defined: the stall port exists and behaves per REQ-019.
REQ-031 Macro undefined: the stall port is absent and stall is treated as constant 0; all other behaviour is identical.

Verification
REQ-032 req, count_in=4, base_addr=0x010, no stall -> four contiguous beats at addresses 0x010-0x013; begin on beat 1, end on beat 4; ack one cycle later.
REQ-033 req, count_in=1, base_addr=0x3FF -> one beat with begin=end=1 at address 0x3FF; ack follows.
REQ-034 req, count_in=0 -> no out_valid; ack high for exactly one cycle; busy high for one cycle.
REQ-035 count_in=3, stall high for 2 cycles after beat 1 (STALL_EN) -> 3 beats total at addresses +0, +1, +2; valid low during the stall; end only on beat 3.
REQ-036 count_in=8, base_addr=0x3FE -> addresses wrap 0x3FE, 0x3FF, 0x000 ... 0x005.
REQ-037 xrst pulsed low during beat 2 of count_in=5; a second req pulsed during RUN of a separate request -> reset: all outputs 0, IDLE; second req: ignored, original request completes unchanged.

Source files
------------

// File: rtl/renkon_ctrl_stream.sv
// Bias-address beat sequencer: IDLE -> RUN -> DONE with registered outputs.
// Optional downstream stall port enabled by RENKON_CTRL_STREAM_STALL_EN.
module renkon_ctrl_stream #(
    parameter int LWIDTH = 16,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [LWIDTH-1:0] count_in,
    input  logic [AWIDTH-1:0] base_addr,
`ifdef RENKON_CTRL_STREAM_STALL_EN
    input  logic              stall,
`endif
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic [AWIDTH-1:0] bias_addr,
    output logic              busy,
    output logic              ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LWIDTH-1:0] rem_q, rem_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              first_q, first_d;
    logic              begin_q, begin_d;
    logic              valid_q, valid_d;
    logic              end_q, end_d;
    logic [AWIDTH-1:0] baddr_q, baddr_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              stall_w;

`ifdef RENKON_CTRL_STREAM_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        first_d = first_q;
        begin_d = 1'b0;
        valid_d = 1'b0;
        end_d   = 1'b0;
        baddr_d = baddr_q;
        ack_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (count_in != '0) begin
                        rem_d   = count_in;
                        addr_d  = base_addr;
                        first_d = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!stall_w) begin
                    valid_d = 1'b1;
                    baddr_d = addr_q;
                    begin_d = first_q;
                    first_d = 1'b0;
                    end_d   = (rem_q == LWIDTH'(1));
                    addr_d  = addr_q + AWIDTH'(1);
                    rem_d   = rem_q - LWIDTH'(1);
                    if (rem_q == LWIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            first_q <= 1'b0;
            begin_q <= 1'b0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            baddr_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            begin_q <= begin_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            baddr_q <= baddr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign out_begin = begin_q;
    assign out_valid = valid_q;
    assign out_end   = end_q;
    assign bias_addr = baddr_q;
    assign busy      = busy_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_renkon_ctrl_stream.sv
// Testbench for renkon_ctrl_stream: directed and random requests vs a
// beat-list reference model; stall scenarios when RENKON_CTRL_STREAM_STALL_EN.
module tb_renkon_ctrl_stream;

    localparam int LW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          xrst;
    logic          req;
    logic [LW-1:0] count_in;
    logic [AW-1:0] base_addr;
    logic          stall;
    logic          out_begin, out_valid, out_end, busy, ack;
    logic [AW-1:0] bias_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    renkon_ctrl_stream #(.LWIDTH(LW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .req       (req),
        .count_in  (count_in),
        .base_addr (base_addr),
`ifdef RENKON_CTRL_STREAM_STALL_EN
        .stall     (stall),
`endif
        .out_begin (out_begin),
        .out_valid (out_valid),
        .out_end   (out_end),
        .bias_addr (bias_addr),
        .busy      (busy),
        .ack       (ack)
    );

    // mode: 0 no stall, 1 random stall, 2 stall two cycles after beat 1
    task automatic run_req(input int cnt, input int base, input bit intrude,
                           input int mode, input string nm);
        int a_s[$];
        int b_s[$];
        int e_s[$];
        int c_s[$];
        int ack_c, acks, busy_n, budget, exp_a;
        bit stalls;
`ifdef RENKON_CTRL_STREAM_STALL_EN
        stalls = (mode != 0);
`else
        stalls = 1'b0;
`endif
        ack_c  = -1;
        acks   = 0;
        busy_n = 0;
        budget = cnt * 4 + 40;
        @(negedge clk);
        req       = 1'b1;
        count_in  = LW'(cnt);
        base_addr = AW'(base);
        stall     = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (out_valid) begin
                a_s.push_back(int'(bias_addr));
                b_s.push_back(int'(out_begin));
                e_s.push_back(int'(out_end));
                c_s.push_back(c);
            end
            if (ack) begin
                acks++;
                ack_c = c;
            end
            if (busy) busy_n++;
            req = intrude && (c == 3);
            if (req) begin
                count_in  = LW'(7);
                base_addr = AW'(10'h200);
            end
            if (mode == 1) stall = ($urandom_range(0, 2) == 0);
            else if (mode == 2) stall = (c == 2 || c == 3);
            else stall = 1'b0;
            if (ack_c >= 0 && c >= ack_c + 4) break;
        end
        stall = 1'b0;
        req   = 1'b0;

        n_cmp++;
        if (acks !== 1) begin
            n_err++;
            $display("FAIL %s ack_count got=%0d exp=1", nm, acks);
        end
        n_cmp++;
        if (a_s.size() !== cnt) begin
            n_err++;
            $display("FAIL %s beats got=%0d exp=%0d", nm, a_s.size(), cnt);
        end
        for (int i = 0; i < a_s.size() && i < cnt; i++) begin
            exp_a = (base + i) % (1 << AW);
            n_cmp++;
            if (a_s[i] !== exp_a || b_s[i] !== int'(i == 0)
                || e_s[i] !== int'(i == cnt - 1)) begin
                n_err++;
                $display("FAIL %s beat%0d got a=%h b=%0d e=%0d exp a=%h b=%0d e=%0d",
                         nm, i, a_s[i], b_s[i], e_s[i], exp_a,
                         int'(i == 0), int'(i == cnt - 1));
            end
        end
        if (acks == 1) begin
            n_cmp++;
            if (busy_n !== ack_c - 1) begin
                n_err++;
                $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, busy_n, ack_c - 1);
            end
            if (cnt > 0 && c_s.size() > 0) begin
                n_cmp++;
                if (ack_c !== c_s[c_s.size()-1] + 1) begin
                    n_err++;
                    $display("FAIL %s ack_cycle got=%0d exp=%0d", nm, ack_c,
                             c_s[c_s.size()-1] + 1);
                end
                n_cmp++;
                if (int'(bias_addr) !== (base + cnt - 1) % (1 << AW)) begin
                    n_err++;
                    $display("FAIL %s addr_hold got=%h exp=%h", nm, bias_addr,
                             (base + cnt - 1) % (1 << AW));
                end
            end
            if (!stalls) begin
                n_cmp++;
                if (ack_c !== cnt + 2) begin
                    n_err++;
                    $display("FAIL %s latency ack_at got=%0d exp=%0d", nm, ack_c, cnt + 2);
                end
                for (int i = 0; i < c_s.size(); i++) begin
                    n_cmp++;
                    if (c_s[i] !== i + 2) begin
                        n_err++;
                        $display("FAIL %s beat_cycle%0d got=%0d exp=%0d", nm, i, c_s[i], i + 2);
                    end
                end
            end
            if (stalls && mode == 2 && c_s.size() == 3) begin
                n_cmp++;
                if (c_s[0] !== 2 || c_s[1] !== 5 || c_s[2] !== 6) begin
                    n_err++;
                    $display("FAIL %s stall_cycles got=%0d,%0d,%0d exp=2,5,6",
                             nm, c_s[0], c_s[1], c_s[2]);
                end
            end
        end
    endtask

    task automatic test_reset();
        xrst  = 1'b0;
        req   = 1'b0;
        stall = 1'b0;
        count_in  = '0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_begin, out_valid, out_end, busy, ack} !== 5'b0 || bias_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state got=%b addr=%h exp=00000 addr=000",
                     {out_begin, out_valid, out_end, busy, ack}, bias_addr);
        end
        xrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle got v=%b busy=%b exp 0 0", out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        req       = 1'b1;
        count_in  = LW'(5);
        base_addr = AW'(10'h123);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || bias_addr !== AW'(10'h124)) begin
            n_err++;
            $display("FAIL rst_mid_beat2 got v=%b a=%h exp v=1 a=124", out_valid, bias_addr);
        end
        #2 xrst = 1'b0;
        #1;
        n_cmp++;
        if ({out_begin, out_valid, out_end, busy, ack} !== 5'b0 || bias_addr !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async got=%b addr=%h exp=00000 addr=000",
                     {out_begin, out_valid, out_end, busy, ack}, bias_addr);
        end
        @(negedge clk);
        xrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet got v=%b busy=%b ack=%b exp 0 0 0",
                         out_valid, busy, ack);
            end
        end
    endtask

    task automatic test_random();
        int cnt, base, mode;
        for (int k = 0; k < 12; k++) begin
            cnt  = $urandom_range(0, 12);
            base = $urandom_range(0, (1 << AW) - 1);
            mode = $urandom_range(0, 1);
            run_req(cnt, base, 1'b0, mode, "random");
        end
    endtask

    initial begin
        test_reset();
        run_req(4, 'h010, 1'b0, 0, "basic4");
        run_req(1, 'h3FF, 1'b0, 0, "single");
        run_req(0, 'h055, 1'b0, 0, "zero");
        run_req(8, 'h3FE, 1'b0, 0, "wrap8");
`ifdef RENKON_CTRL_STREAM_STALL_EN
        run_req(3, 'h040, 1'b0, 2, "stall3");
`endif
        run_req(5, 'h0A0, 1'b1, 0, "intrude");
        test_reset_mid_run();
        run_req(4, 'h2F0, 1'b0, 0, "after_rst");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
